uart_fifo_tx: RTL and testbench

UART_FIFO_TX -- requirements
Module: uart_fifo_tx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_fifo_tx_baud_tick.sv | 34 +++
 rtl/uart_fifo_tx.sv | 121 ++++++++++++
 tb/tb_uart_fifo_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: defaults and FSM encoding.
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

    localparam int DEF_WORD_BITS    = 8;
    localparam int DEF_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd5,
`endif
        ST_STOP   = 3'd6
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_tx_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and pulses tick_o on the last count of each bit.
module baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic restart_i,
    output logic tick_o
);
    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter that pops words from a FIFO and sends them as 8N1-style frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int WORD_BITS    = DEF_WORD_BITS,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 empty_i,
    input  logic [WORD_BITS-1:0] rdata_i,
    output logic                 read_o,
    output logic                 tx_o,
    output logic                 busy_o
);
    // state  | meaning
    // IDLE   | line high, waiting for a non-empty FIFO
    // FETCH  | one-cycle pop strobe
    // LOAD   | FIFO data valid, capture into shift register
    // START  | start bit (low)
    // DATA   | data bits, LSB first
    // PARITY | even parity of the word (optional)
    // STOP   | stop bit (high); last cycle chains to FETCH if more data
    localparam int BIT_CNT_W = $clog2(WORD_BITS + 1);

    tx_state_e            state_q, state_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 baud_restart;
    logic                 bit_tick;
    logic                 last_bit;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .restart_i(baud_restart),
        .tick_o   (bit_tick)
    );

    assign last_bit = (bit_cnt_q == BIT_CNT_W'(WORD_BITS - 1));
    assign tx_o     = tx_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!empty_i) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_START;
            ST_START:  if (bit_tick) state_d = ST_DATA;
`ifdef UART_TX_PARITY_EN
            ST_DATA:   if (bit_tick && last_bit) state_d = ST_PARITY;
            ST_PARITY: if (bit_tick) state_d = ST_STOP;
`else
            ST_DATA:   if (bit_tick && last_bit) state_d = ST_STOP;
`endif
            ST_STOP:   if (bit_tick) state_d = empty_i ? ST_IDLE : ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    // tx_d is derived from the next state so the registered line lines up with state_q.
    always_comb begin
        read_o       = (state_q == ST_FETCH);
        busy_o       = (state_q != ST_IDLE);
        baud_restart = (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_LOAD);
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        if (state_q == ST_LOAD) begin
            shift_d   = rdata_i;
            bit_cnt_d = '0;
        end else if (state_q == ST_DATA && bit_tick) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
`ifdef UART_TX_PARITY_EN
        parity_d = (state_q == ST_LOAD) ? ^rdata_i : parity_q;
`endif
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: a 16-deep FIFO feeds the DUT, the serial line is recorded and decoded.
// Honors UART_TX_PARITY_EN for the frame length and parity bit.
module tb_uart_fifo_tx;
    localparam int C = 4;
    localparam int W = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = W + 3;
`else
    localparam int NB = W + 2;
`endif
    localparam int FRAME = NB * C;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         fifo_empty;
    logic [W-1:0] fifo_rdata = '0;
    logic         read_o, tx_o, busy_o;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;

    always #5 clk_i = ~clk_i;

    uart_fifo_tx #(.WORD_BITS(W), .CLKS_PER_BIT(C)) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .empty_i(fifo_empty),
        .rdata_i(fifo_rdata),
        .read_o (read_o),
        .tx_o   (tx_o),
        .busy_o (busy_o)
    );

    // FIFO with registered read data
    logic [W-1:0] fmem [16];
    int fwr = 0, frd = 0, fcnt = 0;
    assign fifo_empty = (fcnt == 0);
    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fwr <= 0; frd <= 0; fcnt <= 0;
        end else begin
            if (read_o && fcnt != 0) begin
                fifo_rdata <= fmem[frd];
                frd <= (frd + 1) % 16;
            end
            if (wr_en && fcnt < 16) begin
                fmem[fwr] <= wr_data;
                fwr <= (fwr + 1) % 16;
            end
            fcnt <= fcnt + int'(wr_en && fcnt < 16) - int'(read_o && fcnt != 0);
        end
    end

    logic line_q[$];
    logic busyq[$];
    int rd_pulses = 0, bad_reads = 0, dbl_reads = 0;
    logic read_prev = 1'b0;
    always @(negedge clk_i) begin
        line_q.push_back(tx_o);
        busyq.push_back(busy_o);
        if (read_o) begin
            rd_pulses++;
            if (fifo_empty) bad_reads++;
            if (read_prev) dbl_reads++;
        end
        read_prev = read_o;
    end

    int n_checks = 0, n_pass = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic         par_q[$];
    int           start_q[$];
    int           hold_err;

    // Reference decoder: walks the recorded line and extracts frames by bit period.
    task automatic decode(input int from, input int to);
        int i;
        logic [W-1:0] b;
        got_q.delete(); par_q.delete(); start_q.delete();
        hold_err = 0;
        i = from;
        while (i + FRAME <= to) begin
            if (line_q[i] == 1'b0) begin
                for (int k = 0; k < NB; k++)
                    for (int t = 1; t < C; t++)
                        if (line_q[i + k*C + t] != line_q[i + k*C]) hold_err++;
                for (int k = 0; k < W; k++) b[k] = line_q[i + (1 + k)*C];
                if (line_q[i + (NB - 1)*C] != 1'b1) hold_err++;
                got_q.push_back(b);
                par_q.push_back(line_q[i + (W + 1)*C]);
                start_q.push_back(i);
                i += FRAME;
            end else begin
                i++;
            end
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        wr_en = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        @(negedge clk_i);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy_o || !fifo_empty) && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_idle_busy_empty"}, {30'd0, busy_o, fifo_empty}, 32'd1);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic compare_frames(input string tag);
        check({tag, "_nframes"}, got_q.size(), exp_q.size());
        check({tag, "_hold"}, hold_err, 0);
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
            check($sformatf("%s_byte%0d", tag, j), got_q[j], exp_q[j]);
`ifdef UART_TX_PARITY_EN
            check($sformatf("%s_par%0d", tag, j), par_q[j], ^exp_q[j]);
`endif
        end
    endtask

    task automatic gap_check(input string tag);
        for (int j = 1; j < start_q.size(); j++)
            check($sformatf("%s_gap%0d", tag, j), start_q[j] - start_q[j-1] - FRAME, 2);
    endtask

    // Single frame compared sample-for-sample against the ideal waveform.
    task automatic frame_shape(input string tag, input logic [W-1:0] d);
        int m0, s, base;
        logic exp_bits[$];
        logic [C-1:0] got;
        m0 = line_q.size();
        base = rd_pulses;
        exp_q.delete();
        push_word(d);
        wait_idle(tag, FRAME + 40);
        check({tag, "_reads"}, rd_pulses - base, 1);
        s = -1;
        for (int i = m0; i < line_q.size(); i++)
            if (line_q[i] == 1'b0) begin s = i; break; end
        check({tag, "_start_found"}, 32'(s >= 0), 1);
        if (s >= 2 && s + FRAME < line_q.size()) begin
            exp_bits.push_back(1'b0);
            for (int k = 0; k < W; k++) exp_bits.push_back(d[k]);
`ifdef UART_TX_PARITY_EN
            exp_bits.push_back(^d);
`endif
            exp_bits.push_back(1'b1);
            for (int k = 0; k < NB; k++) begin
                for (int t = 0; t < C; t++) got[t] = line_q[s + k*C + t];
                check($sformatf("%s_bit%0d", tag, k), got, {C{exp_bits[k]}});
            end
            check({tag, "_line_after"}, line_q[s + FRAME], 1);
            check({tag, "_busy_stop"}, busyq[s + FRAME - 1], 1);
            check({tag, "_busy_fall"}, busyq[s + FRAME], 0);
            check({tag, "_busy_fetch"}, busyq[s - 2], 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, m1, base, zeros, n;
        repeat (3) @(negedge clk_i);
        check("rst_tx", tx_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_read", read_o, 0);
        reset_i = 1'b0;

        m0 = line_q.size(); base = rd_pulses;
        repeat (100) @(negedge clk_i);
        m1 = line_q.size();
        zeros = 0;
        for (int i = m0; i < m1; i++) if (line_q[i] == 1'b0) zeros++;
        check("empty_reads", rd_pulses - base, 0);
        check("empty_line_low", zeros, 0);

        frame_shape("a5", 8'hA5);

        m0 = line_q.size(); base = rd_pulses; exp_q.delete();
        for (int v = 1; v <= 16; v++) push_word(W'(v));
        wait_idle("burst", 16 * (FRAME + 4) + 50);
        decode(m0, line_q.size());
        compare_frames("burst");
        gap_check("burst");
        check("burst_reads", rd_pulses - base, 16);

        m0 = line_q.size(); exp_q.delete();
        push_word(8'h11);
        n = 0;
        while (tx_o && n < 50) begin @(negedge clk_i); n++; end
        check("late_start_seen", tx_o, 0);
        repeat (FRAME - 3) @(negedge clk_i);
        push_word(8'h3C);
        wait_idle("late", 3 * FRAME);
        decode(m0, line_q.size());
        compare_frames("late");
        gap_check("late");
        if (start_q.size() == 2) begin
            zeros = 0;
            for (int i = start_q[0]; i < start_q[1]; i++) if (busyq[i] == 1'b0) zeros++;
            check("late_no_idle", zeros, 0);
        end

        exp_q.delete();
        push_word(8'h00);
        n = 0;
        while (tx_o && n < 50) begin @(negedge clk_i); n++; end
        repeat (10) @(negedge clk_i);
        check("rst_pre_tx", tx_o, 0);
        check("rst_pre_busy", busy_o, 1);
        #2 reset_i = 1'b1;
        #1;
        check("rst_mid_tx", tx_o, 1);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_read", read_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        m0 = line_q.size(); base = rd_pulses;
        repeat (30) @(negedge clk_i);
        zeros = 0;
        for (int i = m0; i < line_q.size(); i++) if (line_q[i] == 1'b0) zeros++;
        check("post_rst_reads", rd_pulses - base, 0);
        check("post_rst_line", zeros, 0);

        m0 = line_q.size(); base = rd_pulses; exp_q.delete();
        for (int j = 0; j < 24; j++) begin
            repeat ($urandom_range(0, 60)) @(negedge clk_i);
            while (fcnt >= 15) @(negedge clk_i);
            push_word(W'($urandom));
        end
        wait_idle("rand", 24 * (FRAME + 4) + 100);
        decode(m0, line_q.size());
        compare_frames("rand");
        check("rand_reads", rd_pulses - base, 24);

`ifdef UART_TX_PARITY_EN
        frame_shape("p07", 8'h07);
        check("p07_parity", line_q[line_q.size() - 8 - FRAME + (W + 1)*C], 1);
        frame_shape("p03", 8'h03);
        check("p03_parity", line_q[line_q.size() - 8 - FRAME + (W + 1)*C], 0);
`endif

        check("no_read_while_empty", bad_reads, 0);
        check("read_single_cycle", dbl_reads, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
